axi_outstanding_limiter: RTL and testbench



---
 rtl/axi_outstanding_limiter.sv | 202 ++++++++++++++++++++
 tb/tb_axi_outstanding_limiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_outstanding_limiter.sv
// axi_outstanding_limiter: zero-latency AXI4 pass-through that caps outstanding write and read
// transactions toward the downstream slave and offers a level-sensitive drain/halt handshake.
//
// Ports:
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   slv_req_i / slv_resp_o  upstream AXI port (from the channel delay stage)
//   mst_req_o / mst_resp_i  downstream AXI port
//   block_i                 drain request (level)
//   halted_o                drain complete: nothing outstanding, nothing new accepted
//   wr_cnt_o / rd_cnt_o     outstanding write / read transactions
//   wr_stall_cycles_o       cycles an AW was held back (AXI_OUTSTANDING_LIMITER_STATS_EN, else 0)
//   rd_stall_cycles_o       cycles an AR was held back (AXI_OUTSTANDING_LIMITER_STATS_EN, else 0)
//
// Optional feature macro: AXI_OUTSTANDING_LIMITER_STATS_EN enables saturating stall counters.

// Default channel/struct types so the block elaborates stand-alone; real users override
// req_t/resp_t with their own AXI structs carrying the same field names.
package axi_outstanding_limiter_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } resp_t;
endpackage

module axi_outstanding_limiter #(
  parameter int unsigned MaxWrTxns = 8,
  parameter int unsigned MaxRdTxns = 8,
  parameter type req_t  = axi_outstanding_limiter_pkg::req_t,
  parameter type resp_t = axi_outstanding_limiter_pkg::resp_t,
  localparam int unsigned WrCntW = $clog2(MaxWrTxns + 1),
  localparam int unsigned RdCntW = $clog2(MaxRdTxns + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  req_t              slv_req_i,
  output resp_t             slv_resp_o,
  output req_t              mst_req_o,
  input  resp_t             mst_resp_i,
  input  logic              block_i,
  output logic              halted_o,
  output logic [WrCntW-1:0] wr_cnt_o,
  output logic [RdCntW-1:0] rd_cnt_o,
  output logic [31:0]       wr_stall_cycles_o,
  output logic [31:0]       rd_stall_cycles_o
);

  localparam logic [1:0] StRun    = 2'd0;
  localparam logic [1:0] StDrain  = 2'd1;
  localparam logic [1:0] StHalted = 2'd2;

  localparam logic [WrCntW-1:0] WrMax = WrCntW'(MaxWrTxns);
  localparam logic [RdCntW-1:0] RdMax = RdCntW'(MaxRdTxns);

  logic [1:0]        state_q, state_d;
  logic [WrCntW-1:0] wr_cnt_q, wr_cnt_d;
  logic [RdCntW-1:0] rd_cnt_q, rd_cnt_d;

  logic wr_gate, rd_gate;
  logic aw_hs, b_hs, ar_hs, r_last_hs;

  // Gates depend on registered state only, so downstream valid never depends on ready.
  assign wr_gate = (wr_cnt_q == WrMax) || (state_q != StRun);
  assign rd_gate = (rd_cnt_q == RdMax) || (state_q != StRun);

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid && !wr_gate;
    mst_req_o.ar_valid = slv_req_i.ar_valid && !rd_gate;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready && !wr_gate;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready && !rd_gate;
  end

  assign aw_hs     = slv_req_i.aw_valid && !wr_gate && mst_resp_i.aw_ready;
  assign ar_hs     = slv_req_i.ar_valid && !rd_gate && mst_resp_i.ar_ready;
  assign b_hs      = mst_resp_i.b_valid && slv_req_i.b_ready;
  assign r_last_hs = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;

  // A decrement at zero holds the counter at zero; the assertion below flags it.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (aw_hs && !b_hs) begin
      wr_cnt_d = wr_cnt_q + WrCntW'(1);
    end else if (!aw_hs && b_hs && (wr_cnt_q != '0)) begin
      wr_cnt_d = wr_cnt_q - WrCntW'(1);
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (ar_hs && !r_last_hs) begin
      rd_cnt_d = rd_cnt_q + RdCntW'(1);
    end else if (!ar_hs && r_last_hs && (rd_cnt_q != '0)) begin
      rd_cnt_d = rd_cnt_q - RdCntW'(1);
    end
  end

  // Emptiness is judged on next-state counts so HALTED follows the final response directly.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun: begin
        if (block_i) state_d = StDrain;
      end
      StDrain: begin
        if (!block_i) begin
          state_d = StRun;
        end else if ((wr_cnt_d == '0) && (rd_cnt_d == '0)) begin
          state_d = StHalted;
        end
      end
      StHalted: begin
        if (!block_i) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StRun;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign halted_o = (state_q == StHalted);
  assign wr_cnt_o = wr_cnt_q;
  assign rd_cnt_o = rd_cnt_q;

`ifdef AXI_OUTSTANDING_LIMITER_STATS_EN
  logic [31:0] wr_stall_q, rd_stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_stall_q <= '0;
      rd_stall_q <= '0;
    end else begin
      if (slv_req_i.aw_valid && wr_gate && (wr_stall_q != '1)) wr_stall_q <= wr_stall_q + 32'd1;
      if (slv_req_i.ar_valid && rd_gate && (rd_stall_q != '1)) rd_stall_q <= rd_stall_q + 32'd1;
    end
  end

  assign wr_stall_cycles_o = wr_stall_q;
  assign rd_stall_cycles_o = rd_stall_q;
`else
  assign wr_stall_cycles_o = '0;
  assign rd_stall_cycles_o = '0;
`endif

  wr_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(b_hs && !aw_hs && (wr_cnt_q == '0)));
  rd_underflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(r_last_hs && !ar_hs && (rd_cnt_q == '0)));
  wr_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni) wr_cnt_q <= WrMax);
  rd_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni) rd_cnt_q <= RdMax);

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Directed bench for axi_outstanding_limiter with MaxWrTxns = 2, MaxRdTxns = 1.
module tb_axi_outstanding_limiter;
  import axi_outstanding_limiter_pkg::*;

  localparam int unsigned MaxWr = 2;
  localparam int unsigned MaxRd = 1;
`ifdef AXI_OUTSTANDING_LIMITER_STATS_EN
  localparam logic [31:0] StallExp = 32'd5;
`else
  localparam logic [31:0] StallExp = 32'd0;
`endif

  logic        clk;
  logic        rst_n;
  req_t        slv_req;
  resp_t       slv_resp;
  req_t        mst_req;
  resp_t       mst_resp;
  logic        block;
  logic        halted;
  logic [1:0]  wr_cnt;
  logic [0:0]  rd_cnt;
  logic [31:0] wr_stall;
  logic [31:0] rd_stall;

  int errors = 0;
  int checks = 0;

  axi_outstanding_limiter #(
    .MaxWrTxns(MaxWr),
    .MaxRdTxns(MaxRd),
    .req_t    (req_t),
    .resp_t   (resp_t)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .slv_req_i        (slv_req),
    .slv_resp_o       (slv_resp),
    .mst_req_o        (mst_req),
    .mst_resp_i       (mst_resp),
    .block_i          (block),
    .halted_o         (halted),
    .wr_cnt_o         (wr_cnt),
    .rd_cnt_o         (rd_cnt),
    .wr_stall_cycles_o(wr_stall),
    .rd_stall_cycles_o(rd_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    block    = 1'b0;
    slv_req  = '0;
    slv_req.b_ready = 1'b1;
    slv_req.r_ready = 1'b1;
    mst_resp = '0;
    mst_resp.aw_ready = 1'b1;
    mst_resp.ar_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    #12;
    checks++; if (wr_cnt !== 2'd0) begin errors++; $display("FAIL reset_wr_cnt got %0d exp 0", wr_cnt); end
    checks++; if (rd_cnt !== 1'd0) begin errors++; $display("FAIL reset_rd_cnt got %0d exp 0", rd_cnt); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b exp 0", halted); end
    checks++; if (wr_stall !== 32'd0) begin errors++; $display("FAIL reset_wr_stall got %0d exp 0", wr_stall); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_wr_limit();
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = 4'd1;
    #1;
    checks++; if (mst_req.aw_valid !== 1'b1) begin errors++; $display("FAIL wr_aw1_valid got %b exp 1", mst_req.aw_valid); end
    tick();
    slv_req.aw.id = 4'd2;
    tick();
    slv_req.aw.id = 4'd3;
    #1;
    checks++; if (wr_cnt !== 2'd2) begin errors++; $display("FAIL wr_full_cnt got %0d exp 2", wr_cnt); end
    checks++; if (slv_resp.aw_ready !== 1'b0) begin errors++; $display("FAIL wr_third_ready got %b exp 0", slv_resp.aw_ready); end
    checks++; if (mst_req.aw_valid !== 1'b0) begin errors++; $display("FAIL wr_third_valid got %b exp 0", mst_req.aw_valid); end
    checks++; if (mst_req.aw.id !== 4'd3) begin errors++; $display("FAIL wr_aw_payload got %0d exp 3", mst_req.aw.id); end
    tick();
    // return one B while the third AW waits
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = 4'd1;
    #1;
    checks++; if (slv_resp.b_valid !== 1'b1 || slv_resp.b.id !== 4'd1) begin
      errors++; $display("FAIL wr_b_pass got valid=%b id=%0d exp 1/1", slv_resp.b_valid, slv_resp.b.id);
    end
    checks++; if (slv_resp.aw_ready !== 1'b0) begin errors++; $display("FAIL wr_ready_during_b got %b exp 0", slv_resp.aw_ready); end
    tick();
    mst_resp.b_valid = 1'b0;
    #1;
    checks++; if (wr_cnt !== 2'd1) begin errors++; $display("FAIL wr_after_b_cnt got %0d exp 1", wr_cnt); end
    checks++; if (slv_resp.aw_ready !== 1'b1) begin errors++; $display("FAIL wr_third_accept got %b exp 1", slv_resp.aw_ready); end
    tick();
    slv_req.aw_valid = 1'b0;
    checks++; if (wr_cnt !== 2'd2) begin errors++; $display("FAIL wr_refill_cnt got %0d exp 2", wr_cnt); end
    mst_resp.b_valid = 1'b1;
    tick();
    tick();
    mst_resp.b_valid = 1'b0;
    checks++; if (wr_cnt !== 2'd0) begin errors++; $display("FAIL wr_empty_cnt got %0d exp 0", wr_cnt); end
  endtask

  task automatic test_rd_burst();
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = 4'd5;
    tick();
    slv_req.ar.id = 4'd6;
    slv_req.w_valid   = 1'b1;
    slv_req.w.data    = 32'hA5A5_0001;
    #1;
    checks++; if (rd_cnt !== 1'd1) begin errors++; $display("FAIL rd_cnt_after_ar got %0d exp 1", rd_cnt); end
    checks++; if (mst_req.ar_valid !== 1'b0) begin errors++; $display("FAIL rd_second_ar_held got %b exp 0", mst_req.ar_valid); end
    checks++; if (mst_req.w_valid !== 1'b1 || mst_req.w.data !== 32'hA5A5_0001) begin
      errors++; $display("FAIL rd_w_pass got valid=%b data=%h exp 1/a5a50001", mst_req.w_valid, mst_req.w.data);
    end
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rd_cnt !== 1'd1) begin errors++; $display("FAIL rd_beat%0d_cnt got %0d exp 1", i + 1, rd_cnt); end
    end
    slv_req.w_valid = 1'b0;
    mst_resp.r.last = 1'b1;
    #1;
    checks++; if (slv_resp.ar_ready !== 1'b0) begin errors++; $display("FAIL rd_ready_on_last got %b exp 0", slv_resp.ar_ready); end
    tick();
    mst_resp.r_valid = 1'b0;
    mst_resp.r.last  = 1'b0;
    #1;
    checks++; if (rd_cnt !== 1'd0) begin errors++; $display("FAIL rd_cnt_after_last got %0d exp 0", rd_cnt); end
    checks++; if (mst_req.ar_valid !== 1'b1) begin errors++; $display("FAIL rd_second_ar_release got %b exp 1", mst_req.ar_valid); end
    tick();
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    tick();
    mst_resp.r_valid = 1'b0;
    mst_resp.r.last  = 1'b0;
    checks++; if (rd_cnt !== 1'd0) begin errors++; $display("FAIL rd_cnt_final got %0d exp 0", rd_cnt); end
  endtask

  task automatic test_same_cycle();
    slv_req.aw_valid = 1'b1;
    tick();
    mst_resp.b_valid = 1'b1;
    #1;
    checks++; if (mst_req.aw_valid !== 1'b1) begin errors++; $display("FAIL same_aw_valid got %b exp 1", mst_req.aw_valid); end
    tick();
    checks++; if (wr_cnt !== 2'd1) begin errors++; $display("FAIL same_cycle_cnt got %0d exp 1", wr_cnt); end
    slv_req.aw_valid = 1'b0;
    tick();
    mst_resp.b_valid = 1'b0;
    checks++; if (wr_cnt !== 2'd0) begin errors++; $display("FAIL same_cleanup_cnt got %0d exp 0", wr_cnt); end
  endtask

  task automatic test_drain();
    slv_req.aw_valid = 1'b1;
    slv_req.ar_valid = 1'b1;
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.ar_valid = 1'b0;
    block = 1'b1;
    tick();
    slv_req.aw_valid = 1'b1;
    slv_req.ar_valid = 1'b1;
    #1;
    checks++; if (mst_req.aw_valid !== 1'b0) begin errors++; $display("FAIL drain_aw_blocked got %b exp 0", mst_req.aw_valid); end
    checks++; if (mst_req.ar_valid !== 1'b0) begin errors++; $display("FAIL drain_ar_blocked got %b exp 0", mst_req.ar_valid); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL drain_not_halted got %b exp 0", halted); end
    mst_resp.b_valid = 1'b1;
    tick();
    mst_resp.b_valid = 1'b0;
    checks++; if (halted !== 1'b0 || wr_cnt !== 2'd0) begin
      errors++; $display("FAIL drain_after_b got halted=%b wr=%0d exp 0/0", halted, wr_cnt);
    end
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    tick();
    mst_resp.r_valid = 1'b0;
    mst_resp.r.last  = 1'b0;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL drain_halted_rise got %b exp 1", halted); end
    block = 1'b0;
    #1;
    checks++; if (halted !== 1'b1 || mst_req.aw_valid !== 1'b0) begin
      errors++; $display("FAIL halt_hold got halted=%b aw=%b exp 1/0", halted, mst_req.aw_valid);
    end
    tick();
    checks++; if (halted !== 1'b0 || mst_req.aw_valid !== 1'b1) begin
      errors++; $display("FAIL resume got halted=%b aw=%b exp 0/1", halted, mst_req.aw_valid);
    end
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.ar_valid = 1'b0;
    checks++; if (wr_cnt !== 2'd1 || rd_cnt !== 1'd1) begin
      errors++; $display("FAIL resume_cnts got wr=%0d rd=%0d exp 1/1", wr_cnt, rd_cnt);
    end
    mst_resp.b_valid = 1'b1;
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last  = 1'b1;
    tick();
    mst_resp.b_valid = 1'b0;
    mst_resp.r_valid = 1'b0;
    mst_resp.r.last  = 1'b0;
  endtask

  task automatic test_async_reset();
    slv_req.aw_valid = 1'b1;
    tick();
    tick();
    block = 1'b1;
    tick();
    checks++; if (wr_cnt !== 2'd2 || mst_req.aw_valid !== 1'b0) begin
      errors++; $display("FAIL areset_setup got wr=%0d aw=%b exp 2/0", wr_cnt, mst_req.aw_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (wr_cnt !== 2'd0 || rd_cnt !== 1'd0 || halted !== 1'b0) begin
      errors++; $display("FAIL areset_state got wr=%0d rd=%0d halted=%b exp 0/0/0", wr_cnt, rd_cnt, halted);
    end
    checks++; if (mst_req.aw_valid !== 1'b1) begin errors++; $display("FAIL areset_run got %b exp 1", mst_req.aw_valid); end
    checks++; if (wr_stall !== 32'd0) begin errors++; $display("FAIL areset_stall got %0d exp 0", wr_stall); end
    slv_req.aw_valid = 1'b0;
    block = 1'b0;
    #10;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_stats();
    slv_req.aw_valid = 1'b1;
    tick();
    tick();
    repeat (5) tick();
    slv_req.aw_valid = 1'b0;
    tick();
    checks++; if (wr_stall !== StallExp) begin errors++; $display("FAIL stats_wr got %0d exp %0d", wr_stall, StallExp); end
    checks++; if (rd_stall !== 32'd0) begin errors++; $display("FAIL stats_rd got %0d exp 0", rd_stall); end
    mst_resp.b_valid = 1'b1;
    tick();
    tick();
    mst_resp.b_valid = 1'b0;
    checks++; if (wr_cnt !== 2'd0) begin errors++; $display("FAIL stats_cleanup got %0d exp 0", wr_cnt); end
  endtask

  initial begin
    test_reset();
    test_wr_limit();
    test_rd_burst();
    test_same_cycle();
    test_drain();
    test_async_reset();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
